// File: rtl/mem_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mem_seq_ctrl
// Self-counting sequencer for the two-memory datapath. One run goes through
// IDLE -> LOAD -> PRIME -> PROC -> DONE -> IDLE:
//   LOAD  : DEPTH_A cycles writing memory A (WEA, IncA)
//   PRIME : PIPE_LAT cycles while the first A reads travel down the pipe
//   PROC  : DEPTH_A/RATIO result slots of RATIO cycles each
//           (slot cycle 0 -> WEB, slot cycle 1 -> IncB)
//   DONE  : a single cycle with done=1
// A reads (IncA) start on the first PRIME cycle and continue once per
// unstalled cycle until DEPTH_A words have been read.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-low reset
//   start  in   1      run request, sampled only in IDLE
//   hold   in   1      stall request, honoured in LOAD/PRIME/PROC
//   WEA    out  1      memory-A write enable
//   IncA   out  1      memory-A address increment
//   WEB    out  1      memory-B write enable
//   IncB   out  1      memory-B address increment
//   busy   out  1      high in LOAD/PRIME/PROC
//   done   out  1      one-cycle end-of-run pulse
//   count  out  CNT_W  step counter (0 in IDLE, 1 on first LOAD cycle)
// -----------------------------------------------------------------------------
module mem_seq_ctrl #(
    parameter int DEPTH_A  = 8,
    parameter int RATIO    = 2,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             WEA,
    output logic             IncA,
    output logic             WEB,
    output logic             IncB,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int NRES = DEPTH_A / RATIO;
    // Highest count value reached in PROC; DONE shows LAST+1.
    localparam int LAST = DEPTH_A + PIPE_LAT + NRES * RATIO;

    // Elaboration-time parameter sanity checks.
    if (RATIO < 2) begin : g_chk_ratio
        $error("mem_seq_ctrl: RATIO must be >= 2");
    end
    if ((RATIO >= 2) && ((DEPTH_A % RATIO) != 0 || DEPTH_A < RATIO)) begin : g_chk_depth
        $error("mem_seq_ctrl: DEPTH_A must be a non-zero multiple of RATIO");
    end
    if (PIPE_LAT < 1) begin : g_chk_pipe
        $error("mem_seq_ctrl: PIPE_LAT must be >= 1");
    end
    if (LAST + 1 > (2 ** CNT_W) - 1) begin : g_chk_cntw
        $error("mem_seq_ctrl: CNT_W too small for the run length");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_PROC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] ZERO      = '0;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_END  = CNT_W'(DEPTH_A - 1);
    localparam logic [CNT_W-1:0] PRIME_END = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] RES_END   = CNT_W'(NRES - 1);
    localparam logic [CNT_W-1:0] RD_MAX    = CNT_W'(DEPTH_A);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] step_q,  step_d;   // cycle index inside LOAD / PRIME
    logic [CNT_W-1:0] slot_q,  slot_d;   // cycle index inside a PROC slot
    logic [CNT_W-1:0] res_q,   res_d;    // result slot index inside PROC
    logic [CNT_W-1:0] rd_q,    rd_d;     // A reads issued so far, current cycle included
    logic             wea_q,  wea_d;
    logic             inca_q, inca_d;
    logic             web_q,  web_d;
    logic             incb_q, incb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frozen;

    // Position update. hold is sampled at the clock edge: the cycle after an
    // edge with hold=1 repeats the current position with all strobes low, so
    // the remaining schedule is simply shifted by the stall length.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        step_d  = step_q;
        slot_d  = slot_q;
        res_d   = res_q;
        rd_d    = rd_q;
        frozen  = 1'b0;

        case (state_q)
            S_IDLE: begin
                count_d = ZERO;
                if (start) begin
                    state_d = S_LOAD;
                    count_d = ONE;
                    step_d  = ZERO;
                    slot_d  = ZERO;
                    res_d   = ZERO;
                    rd_d    = ZERO;
                end
            end
            S_LOAD, S_PRIME, S_PROC: begin
                if (hold) begin
                    frozen = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                    if (state_q == S_LOAD) begin
                        if (step_q == LOAD_END) begin
                            state_d = S_PRIME;
                            step_d  = ZERO;
                        end else begin
                            step_d = step_q + ONE;
                        end
                    end else if (state_q == S_PRIME) begin
                        if (step_q == PRIME_END) begin
                            state_d = S_PROC;
                            slot_d  = ZERO;
                            res_d   = ZERO;
                        end else begin
                            step_d = step_q + ONE;
                        end
                    end else begin
                        if (slot_q == SLOT_END) begin
                            slot_d = ZERO;
                            if (res_q == RES_END) begin
                                state_d = S_DONE;
                            end else begin
                                res_d = res_q + ONE;
                            end
                        end else begin
                            slot_d = slot_q + ONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = ZERO;
            end
            default: begin
                state_d = S_IDLE;
                count_d = ZERO;
            end
        endcase
    end

    // Output decode of the next position, registered below.
    always_comb begin
        wea_d  = 1'b0;
        inca_d = 1'b0;
        web_d  = 1'b0;
        incb_d = 1'b0;
        busy_d = (state_d == S_LOAD) || (state_d == S_PRIME) || (state_d == S_PROC);
        done_d = (state_d == S_DONE);
        if (!frozen) begin
            if (state_d == S_LOAD) begin
                wea_d  = 1'b1;
                inca_d = 1'b1;
            end
            if ((state_d == S_PRIME) || (state_d == S_PROC)) begin
                inca_d = (rd_q < RD_MAX);
            end
            if (state_d == S_PROC) begin
                web_d  = (slot_d == ZERO);
                incb_d = (slot_d == ONE);
            end
        end
    end

    // Read counter follows the IncA decision for the coming cycle.
    logic [CNT_W-1:0] rd_next;
    always_comb begin
        rd_next = rd_d;
        if (inca_d && ((state_d == S_PRIME) || (state_d == S_PROC))) begin
            rd_next = rd_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= ZERO;
            step_q  <= ZERO;
            slot_q  <= ZERO;
            res_q   <= ZERO;
            rd_q    <= ZERO;
            wea_q   <= 1'b0;
            inca_q  <= 1'b0;
            web_q   <= 1'b0;
            incb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            step_q  <= step_d;
            slot_q  <= slot_d;
            res_q   <= res_d;
            rd_q    <= rd_next;
            wea_q   <= wea_d;
            inca_q  <= inca_d;
            web_q   <= web_d;
            incb_q  <= incb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign WEA   = wea_q;
    assign IncA  = inca_q;
    assign WEB   = web_q;
    assign IncB  = incb_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule
